// File: rtl/alu_pkg.sv
// Shared ALU control encodings and the operand/response records used around the shared ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_SLL  = 4'h4;
    localparam logic [3:0] ALU_SLT  = 4'h5;
    localparam logic [3:0] ALU_XOR  = 4'h6;
    localparam logic [3:0] ALU_SRL  = 4'h7;
    localparam logic [3:0] ALU_SLTU = 4'h8;
    localparam logic [3:0] ALU_SRA  = 4'hF;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [3:0]  tag;
    } alu_op_t;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        sign;
        logic        err;
        logic [3:0]  tag;
    } alu_rsp_t;

    // Codes 9..E are unassigned.
    function automatic logic alu_ctrl_legal(input logic [3:0] ctrl);
        return (ctrl <= ALU_SLTU) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; result is undefined for unassigned control codes.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  ctrl,
    output logic [31:0] result,
    output logic        zero,
    output logic        sign
);

    always_comb begin
        result = 'x;
        case (ctrl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SLTU: result = {31'd0, a < b};
            ALU_SRA:  result = $signed(a) >>> b[4:0];
            default:  result = 'x;
        endcase
    end

    assign zero = (result == 32'd0);
    assign sign = result[31];

endmodule

// File: rtl/alu_share_arbiter.sv
// Arbitrates one shared ALU between the EX stage (req0, priority) and the CNN coprocessor (req1,
// with starvation override), registering each result into a per-requester 1-entry response slot.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [3:0]       req0_ctrl,
    input  logic [3:0]       req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [3:0]       req1_ctrl,
    input  logic [3:0]       req1_tag,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp0_sign,
    output logic             rsp0_err,
    output logic [3:0]       rsp0_tag,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_result,
    output logic             rsp1_zero,
    output logic             rsp1_sign,
    output logic             rsp1_err,
    output logic [3:0]       rsp1_tag,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    alu_op_t        op [2];
    alu_op_t        sel_op;
    alu_rsp_t       new_rsp;
    alu_rsp_t       slot_q [2];
    alu_rsp_t       slot_d [2];
    logic [1:0]     req_valid, rsp_ready, slot_free, elig, gnt;
    logic [1:0]     valid_q, valid_d;
    logic [3:0]     starve_q, starve_d;
    logic [CNT_W-1:0] conflict_q, conflict_d;
    logic           force1;
    logic [31:0]    alu_result;
    logic           alu_zero, alu_sign;

    assign op[0]     = '{a: req0_a, b: req0_b, ctrl: req0_ctrl, tag: req0_tag};
    assign op[1]     = '{a: req1_a, b: req1_b, ctrl: req1_ctrl, tag: req1_tag};
    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    assign slot_free = ~valid_q | rsp_ready;
    assign elig      = req_valid & slot_free;

    // rst_n gating keeps ready low for the whole reset window, not just until the next edge.
    always_comb begin
        force1 = (starve_q == LIMIT);
        gnt[1] = rst_n & elig[1] & (~elig[0] | force1);
        gnt[0] = rst_n & elig[0] & ~gnt[1];
        sel_op = '{a: 32'd0, b: 32'd0, ctrl: ALU_ADD, tag: 4'd0};
        if (gnt[1]) begin
            sel_op = op[1];
        end else if (gnt[0]) begin
            sel_op = op[0];
        end
    end

    alu u_alu (
        .a      (sel_op.a),
        .b      (sel_op.b),
        .ctrl   (sel_op.ctrl),
        .result (alu_result),
        .zero   (alu_zero),
        .sign   (alu_sign)
    );

    // Illegal codes are masked here so the ALU's undefined output never reaches a slot.
    always_comb begin
        new_rsp.err    = !alu_ctrl_legal(sel_op.ctrl);
        new_rsp.result = new_rsp.err ? 32'd0 : alu_result;
        new_rsp.zero   = new_rsp.err ? 1'b1  : alu_zero;
        new_rsp.sign   = new_rsp.err ? 1'b0  : alu_sign;
        new_rsp.tag    = sel_op.tag;
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            slot_d[i]  = slot_q[i];
            valid_d[i] = valid_q[i];
            if (gnt[i]) begin
                slot_d[i]  = new_rsp;
                valid_d[i] = 1'b1;
            end else if (rsp_ready[i]) begin
                valid_d[i] = 1'b0;
            end
        end

        starve_d = starve_q;
        if (gnt[1] || !req_valid[1]) begin
            starve_d = 4'd0;
        end else if (elig[1] && !force1) begin
            starve_d = starve_q + 4'd1;
        end

        conflict_d = conflict_q + CNT_W'(elig[0] & elig[1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= '0;
            end
            valid_q    <= '0;
            starve_q   <= '0;
            conflict_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= slot_d[i];
            end
            valid_q    <= valid_d;
            starve_q   <= starve_d;
            conflict_q <= conflict_d;
        end
    end

    assign req0_ready   = gnt[0];
    assign req1_ready   = gnt[1];
    assign rsp0_valid   = valid_q[0];
    assign rsp0_result  = slot_q[0].result;
    assign rsp0_zero    = slot_q[0].zero;
    assign rsp0_sign    = slot_q[0].sign;
    assign rsp0_err     = slot_q[0].err;
    assign rsp0_tag     = slot_q[0].tag;
    assign rsp1_valid   = valid_q[1];
    assign rsp1_result  = slot_q[1].result;
    assign rsp1_zero    = slot_q[1].zero;
    assign rsp1_sign    = slot_q[1].sign;
    assign rsp1_err     = slot_q[1].err;
    assign rsp1_tag     = slot_q[1].tag;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: stimulus pushes hand-computed responses into per-requester
// queues, and a negedge monitor pops and compares each response as it is consumed.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        sign;
        logic        err;
        logic [3:0]  tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0]      req0_a, req0_b, req1_a, req1_b;
    logic [3:0]       req0_ctrl, req0_tag, req1_ctrl, req1_tag;
    logic             rsp0_valid, rsp0_ready, rsp0_zero, rsp0_sign, rsp0_err;
    logic             rsp1_valid, rsp1_ready, rsp1_zero, rsp1_sign, rsp1_err;
    logic [31:0]      rsp0_result, rsp1_result;
    logic [3:0]       rsp0_tag, rsp1_tag;
    logic [CNT_W-1:0] conflict_cnt;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.STARVE_LIMIT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctrl(req0_ctrl), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctrl(req1_ctrl), .req1_tag(req1_tag),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_zero(rsp0_zero), .rsp0_sign(rsp0_sign), .rsp0_err(rsp0_err), .rsp0_tag(rsp0_tag),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_zero(rsp1_zero), .rsp1_sign(rsp1_sign), .rsp1_err(rsp1_err), .rsp1_tag(rsp1_tag),
        .conflict_cnt(conflict_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] ctrl, input logic [3:0] tag);
        req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = ctrl; req0_tag = tag;
    endtask

    task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] ctrl, input logic [3:0] tag);
        req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = ctrl; req1_tag = tag;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a response is consumed at the next edge when valid & ready, so compare it now.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) begin
                    check("rsp0_unexpected", 64'(q0.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    check("rsp0_result", 64'(rsp0_result), 64'(e.result));
                    check("rsp0_flags", {61'd0, rsp0_zero, rsp0_sign, rsp0_err},
                          {61'd0, e.zero, e.sign, e.err});
                    check("rsp0_tag", 64'(rsp0_tag), 64'(e.tag));
                    $display("rsp0 tag=%0d result=0x%08h z=%0b s=%0b e=%0b",
                             rsp0_tag, rsp0_result, rsp0_zero, rsp0_sign, rsp0_err);
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) begin
                    check("rsp1_unexpected", 64'(q1.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    check("rsp1_result", 64'(rsp1_result), 64'(e.result));
                    check("rsp1_flags", {61'd0, rsp1_zero, rsp1_sign, rsp1_err},
                          {61'd0, e.zero, e.sign, e.err});
                    check("rsp1_tag", 64'(rsp1_tag), 64'(e.tag));
                    $display("rsp1 tag=%0d result=0x%08h z=%0b s=%0b e=%0b",
                             rsp1_tag, rsp1_result, rsp1_zero, rsp1_sign, rsp1_err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic g1;
        rst_n = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set_req0(1'b1, 32'd1, 32'd1, ALU_ADD, 4'd1);
        set_req1(1'b0, 32'd0, 32'd0, ALU_ADD, 4'd0);

        // Reset state, with req0 offered to prove ready stays low.
        to_neg();
        check("rst_ready0", 64'(req0_ready), 64'd0);
        check("rst_rsp_valid", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
        check("rst_result0", 64'(rsp0_result), 64'd0);
        check("rst_conflict", 64'(conflict_cnt), 64'd0);
        to_drive();
        to_drive();
        set_req0(1'b0, 32'd0, 32'd0, ALU_ADD, 4'd0);
        rst_n = 1'b1;

        // 1: single SUB on req0, one-cycle latency.
        set_req0(1'b1, 32'd5, 32'd3, ALU_SUB, 4'd2);
        to_neg();
        check("t1_ready0", 64'(req0_ready), 64'd1);
        check("t1_ready1", 64'(req1_ready), 64'd0);
        q0.push_back('{result: 32'd2, zero: 1'b0, sign: 1'b0, err: 1'b0, tag: 4'd2});
        to_drive();
        set_req0(1'b0, 32'd0, 32'd0, ALU_ADD, 4'd0);
        to_neg();
        check("t1_rsp0_valid", 64'(rsp0_valid), 64'd1);
        to_drive();

        // 2: both valid, req1 wins every 5th cycle via the starvation override.
        for (int k = 0; k < 10; k++) begin
            set_req0(1'b1, 32'(k), 32'd100, ALU_ADD, 4'(k));
            set_req1(1'b1, 32'(k), 32'd7, ALU_OR, 4'(k + 1));
            g1 = ((k % 5) == 4);
            to_neg();
            check("t2_ready0", 64'(req0_ready), 64'(!g1));
            check("t2_ready1", 64'(req1_ready), 64'(g1));
            if (g1) q1.push_back('{result: 32'(k) | 32'd7, zero: 1'b0, sign: 1'b0, err: 1'b0, tag: 4'(k + 1)});
            else    q0.push_back('{result: 32'(k) + 32'd100, zero: 1'b0, sign: 1'b0, err: 1'b0, tag: 4'(k)});
            to_drive();
        end
        set_req0(1'b0, 32'd0, 32'd0, ALU_ADD, 4'd0);
        set_req1(1'b0, 32'd0, 32'd0, ALU_ADD, 4'd0);
        to_neg();
        check("t2_conflict", 64'(conflict_cnt), 64'd10);
        to_drive();

        // 3: slot0 full and stalled; req1 flows every cycle, slot0 held.
        rsp0_ready = 1'b0;
        set_req0(1'b1, 32'd40, 32'd2, ALU_ADD, 4'd5);
        to_neg();
        check("t3_load_ready0", 64'(req0_ready), 64'd1);
        q0.push_back('{result: 32'd42, zero: 1'b0, sign: 1'b0, err: 1'b0, tag: 4'd5});
        to_drive();
        for (int k = 0; k < 6; k++) begin
            set_req0(1'b1, 32'(k), 32'(k), ALU_SUB, 4'd6);
            set_req1(1'b1, 32'(k), 32'(k + 1), ALU_SUB, 4'd3);
            to_neg();
            check("t3_ready0", 64'(req0_ready), 64'd0);
            check("t3_ready1", 64'(req1_ready), 64'd1);
            check("t3_hold", {27'd0, rsp0_valid, rsp0_tag, rsp0_result}, {27'd0, 1'b1, 4'd5, 32'd42});
            q1.push_back('{result: 32'hFFFF_FFFF, zero: 1'b0, sign: 1'b1, err: 1'b0, tag: 4'd3});
            to_drive();
        end
        set_req0(1'b0, 32'd0, 32'd0, ALU_ADD, 4'd0);
        set_req1(1'b0, 32'd0, 32'd0, ALU_ADD, 4'd0);
        rsp0_ready = 1'b1;
        to_neg();
        check("t3_conflict", 64'(conflict_cnt), 64'd10);
        to_drive();

        // 4: illegal ctrl on req1.
        set_req1(1'b1, 32'd7, 32'd3, 4'hA, 4'd9);
        to_neg();
        check("t4_ready1", 64'(req1_ready), 64'd1);
        q1.push_back('{result: 32'd0, zero: 1'b1, sign: 1'b0, err: 1'b1, tag: 4'd9});
        to_drive();
        set_req1(1'b0, 32'd0, 32'd0, ALU_ADD, 4'd0);
        to_neg();
        check("t4_no_x", 64'($isunknown({rsp1_result, rsp1_zero, rsp1_sign, rsp1_err, rsp1_tag,
                                        rsp0_result, rsp0_valid, rsp1_valid, conflict_cnt})), 64'd0);
        to_drive();

        // 5: back-to-back ADDs on req0.
        for (int i = 0; i < 8; i++) begin
            set_req0(1'b1, 32'(i), 32'd1, ALU_ADD, 4'(i));
            to_neg();
            check("t5_ready0", 64'(req0_ready), 64'd1);
            q0.push_back('{result: 32'(i + 1), zero: 1'b0, sign: 1'b0, err: 1'b0, tag: 4'(i)});
            to_drive();
        end
        set_req0(1'b0, 32'd0, 32'd0, ALU_ADD, 4'd0);
        to_neg();
        to_drive();

        // 6: build starve count 3, then reset asynchronously mid-cycle.
        for (int k = 0; k < 3; k++) begin
            set_req0(1'b1, 32'(k), 32'd0, ALU_ADD, 4'(k));
            set_req1(1'b1, 32'd1, 32'd1, ALU_ADD, 4'd1);
            to_neg();
            check("t6_pre_ready0", 64'(req0_ready), 64'd1);
            q0.push_back('{result: 32'(k), zero: (k == 0), sign: 1'b0, err: 1'b0, tag: 4'(k)});
            to_drive();
        end
        check("t6_pre_rsp0_valid", 64'(rsp0_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_rsp", {26'd0, rsp1_valid, rsp0_valid, rsp0_tag, rsp0_result}, 64'd0);
        check("t6_rst_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
        check("t6_rst_conflict", 64'(conflict_cnt), 64'd0);
        q0.delete();
        q1.delete();
        to_drive();
        to_drive();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_req0(1'b1, 32'd10, 32'(k), ALU_ADD, 4'(k));
            set_req1(1'b1, 32'd20, 32'(k), ALU_SUB, 4'(k + 8));
            g1 = (k == 4);
            to_neg();
            check("t6_ready0", 64'(req0_ready), 64'(!g1));
            check("t6_ready1", 64'(req1_ready), 64'(g1));
            if (g1) q1.push_back('{result: 32'(20 - k), zero: 1'b0, sign: 1'b0, err: 1'b0, tag: 4'(k + 8)});
            else    q0.push_back('{result: 32'(10 + k), zero: 1'b0, sign: 1'b0, err: 1'b0, tag: 4'(k)});
            to_drive();
        end
        set_req0(1'b0, 32'd0, 32'd0, ALU_ADD, 4'd0);
        set_req1(1'b0, 32'd0, 32'd0, ALU_ADD, 4'd0);
        to_neg();
        to_drive();
        to_neg();
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
